// File: rtl/prog_loader.sv
// prog_loader: streams user bytes into CPU RAM over the shared bus.
// Each byte accepted in IDLE runs ADDR -> DATA -> WRITE -> NEXT, one cycle per
// state, driving the MAR, the MAR data latch and a RAM load pulse in turn.
// Optional build macro PROG_VERIFY_EN inserts a READ state after WRITE and
// compares the RAM readback on bus_in against the written byte.
module prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              programming,
    input  logic              new_byte,
    input  logic              addr_set,
    input  logic [DATA_W-1:0] ui_in,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [CTRL_W-1:0] ctrl,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              verify_err
);

    // Control word bit map (active-low names end in _N):
    //   14 PC_INC  13 PC_EN  12 PC_LOAD  11 MAR_ADDR_LOAD_N  10 MAR_MEM_LOAD_N
    //    9 RAM_EN_N  8 RAM_LOAD_N  7 IR_LOAD_N  6 IR_EN_N  5 REGA_LOAD_N
    //    4 REGA_EN  3 ADDER_SUB  2 REGB_EN  1 REGB_LOAD_N  0 OUT_LOAD_N
    localparam logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(15'h0FE3);
    localparam int B_MAR_ADDR_LOAD_N = 11;
    localparam int B_MAR_MEM_LOAD_N  = 10;
    localparam int B_RAM_LOAD_N      = 8;
`ifdef PROG_VERIFY_EN
    localparam int B_RAM_EN_N        = 9;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_new_byte_q;
    logic              w_edge;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_bus_out;
    logic              r_bus_oe;
    logic              r_done;
    logic              r_overrun;

    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [DATA_W-1:0] w_bus_out_nxt;
    logic              w_bus_oe_nxt;
    logic              w_done_nxt;
    logic              w_addr_top;

    assign w_edge     = new_byte & ~r_new_byte_q;
    assign w_addr_top = (r_addr == '1);

    // Byte strobe history for rising-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_new_byte_q <= 1'b0;
        end else begin
            r_new_byte_q <= new_byte;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; leaving programming mode always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (!programming) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_edge) w_state_nxt = S_ADDR;
                S_ADDR:  w_state_nxt = S_DATA;
                S_DATA:  w_state_nxt = S_WRITE;
`ifdef PROG_VERIFY_EN
                S_WRITE: w_state_nxt = S_READ;
                S_READ:  w_state_nxt = S_NEXT;
`else
                S_WRITE: w_state_nxt = S_NEXT;
`endif
                S_NEXT:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode of the upcoming state, so the registered outputs line up
    // with the state they belong to rather than lagging it by a cycle
    always_comb begin
        w_ctrl_nxt    = CTRL_IDLE;
        w_bus_out_nxt = '0;
        w_bus_oe_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        case (w_state_nxt)
            S_ADDR: begin
                w_bus_out_nxt[ADDR_W-1:0]     = r_addr;
                w_bus_oe_nxt                  = 1'b1;
                w_ctrl_nxt[B_MAR_ADDR_LOAD_N] = 1'b0;
            end
            S_DATA: begin
                w_bus_out_nxt                = r_data;
                w_bus_oe_nxt                 = 1'b1;
                w_ctrl_nxt[B_MAR_MEM_LOAD_N] = 1'b0;
            end
            S_WRITE: begin
                w_bus_out_nxt            = r_data;
                w_bus_oe_nxt             = 1'b1;
                w_ctrl_nxt[B_RAM_LOAD_N] = 1'b0;
            end
`ifdef PROG_VERIFY_EN
            S_READ: begin
                w_ctrl_nxt[B_RAM_EN_N] = 1'b0;
            end
`endif
            S_NEXT: begin
                w_done_nxt = w_addr_top;
            end
            default: begin
                w_ctrl_nxt = CTRL_IDLE;
            end
        endcase
    end

    // Registered bus / control outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ctrl    <= CTRL_IDLE;
            r_bus_out <= '0;
            r_bus_oe  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_bus_out <= w_bus_out_nxt;
            r_bus_oe  <= w_bus_oe_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Byte capture and write-address tracking; a byte edge wins over addr_set
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data <= '0;
            r_addr <= '0;
        end else if (!programming) begin
            r_addr <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_edge) begin
                r_data <= ui_in;
            end else if (addr_set) begin
                r_addr <= ui_in[ADDR_W-1:0];
            end
        end else if (r_state == S_NEXT) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Sticky overrun: a byte edge while a sequence is in flight is dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
        end else if (!programming) begin
            r_overrun <= 1'b0;
        end else if (w_edge && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef PROG_VERIFY_EN
    logic r_verify_err;

    // Sticky readback check at the end of READ; only reset clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_verify_err <= 1'b0;
        end else if ((r_state == S_READ) && (bus_in != r_data)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
`else
    logic w_unused_bus_in;
    assign w_unused_bus_in = ^bus_in;
    assign verify_err      = 1'b0;
`endif

    assign bus_out = r_bus_out;
    assign bus_oe  = r_bus_oe;
    assign ctrl    = r_ctrl;
    assign addr    = r_addr;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. A small RAM emulation watches the
// control word the way the CPU would (MAR latch, data latch, RAM load) and is
// compared with a byte-stream model of where each accepted byte must land.
module tb_prog_loader;

`ifdef PROG_VERIFY_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        programming = 1'b0;
    logic        new_byte = 1'b0;
    logic        addr_set = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [14:0] ctrl;
    logic [3:0]  addr;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        verify_err;

    int errors = 0;
    int checks = 0;

    prog_loader #(.DATA_W(8), .ADDR_W(4), .CTRL_W(15)) dut (
        .clk(clk), .resetn(resetn), .programming(programming),
        .new_byte(new_byte), .addr_set(addr_set), .ui_in(ui_in),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .ctrl(ctrl),
        .addr(addr), .busy(busy), .done(done), .overrun(overrun),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // CPU-side RAM emulation driven purely by the control word
    logic [3:0] mar = 4'h0;
    logic [7:0] mdr = 8'h00;
    logic [7:0] mem [16];
    int         wr_count = 0;
    int         done_count = 0;
    logic       corrupt = 1'b0;

    assign bus_in = corrupt ? ~mem[mar] : mem[mar];

    always @(negedge clk) begin
        if (resetn) begin
            if (!ctrl[11]) mar = bus_out[3:0];
            if (!ctrl[10]) mdr = bus_out;
            if (!ctrl[8]) begin
                mem[mar] = mdr;
                wr_count++;
            end
            if (done) done_count++;
        end
    end

    // Byte-stream reference model
    logic [7:0] exp_mem [16];
    int         exp_addr = 0;
    int         exp_done = 0;

    task automatic model_accept(input logic [7:0] b);
        exp_mem[exp_addr] = b;
        if (exp_addr == 15) exp_done++;
        exp_addr = (exp_addr + 1) % 16;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 16 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b, required 0 within bound", busy);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        ui_in    = b;
        new_byte = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        new_byte = 1'b0;
        wait_idle();
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (ctrl !== 15'h0FE3 || bus_oe !== 1'b0 || bus_out !== 8'h00 ||
            addr !== 4'h0 || busy !== 1'b0 || done !== 1'b0 ||
            overrun !== 1'b0 || verify_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ctrl=%h oe=%b out=%h addr=%h busy=%b done=%b ovr=%b verr=%b, required 0fe3 0 00 0 0 0 0 0",
                     ctrl, bus_oe, bus_out, addr, busy, done, overrun, verify_err);
        end
        resetn      = 1'b1;
        programming = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        int wc;
        wc       = wr_count;
        ui_in    = 8'hA5;
        new_byte = 1'b1;
        tick();
        checks++;
        if (ctrl !== 15'h07E3 || bus_out !== 8'h00 || bus_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL a5_addr: ctrl=%h out=%h oe=%b busy=%b, required 07e3 00 1 1", ctrl, bus_out, bus_oe, busy);
        end
        new_byte = 1'b0;
        tick();
        checks++;
        if (ctrl !== 15'h0BE3 || bus_out !== 8'hA5 || bus_oe !== 1'b1) begin
            errors++;
            $display("FAIL a5_data: ctrl=%h out=%h oe=%b, required 0be3 a5 1", ctrl, bus_out, bus_oe);
        end
        tick();
        checks++;
        if (ctrl !== 15'h0EE3 || bus_out !== 8'hA5 || bus_oe !== 1'b1) begin
            errors++;
            $display("FAIL a5_write: ctrl=%h out=%h oe=%b, required 0ee3 a5 1", ctrl, bus_out, bus_oe);
        end
`ifdef PROG_VERIFY_EN
        tick();
        checks++;
        if (ctrl !== 15'h0DE3 || bus_oe !== 1'b0) begin
            errors++;
            $display("FAIL a5_read: ctrl=%h oe=%b, required 0de3 0", ctrl, bus_oe);
        end
`endif
        tick();
        checks++;
        if (ctrl !== 15'h0FE3 || busy !== 1'b1 || done !== 1'b0 || bus_oe !== 1'b0) begin
            errors++;
            $display("FAIL a5_next: ctrl=%h busy=%b done=%b oe=%b, required 0fe3 1 0 0", ctrl, busy, done, bus_oe);
        end
        tick();
        model_accept(8'hA5);
        checks++;
        if (busy !== 1'b0 || addr !== 4'(exp_addr) || mem[0] !== 8'hA5 ||
            wr_count !== wc + 1 || verify_err !== 1'b0) begin
            errors++;
            $display("FAIL a5_end: busy=%b addr=%h mem0=%h writes=%0d verr=%b, required 0 %h a5 %0d 0",
                     busy, addr, mem[0], wr_count - wc, verify_err, 4'(exp_addr), 1);
        end
    endtask

    task automatic test_wrap_done();
        int d0;
        d0       = done_count;
        ui_in    = 8'h0E;
        addr_set = 1'b1;
        tick();
        addr_set = 1'b0;
        exp_addr = 14;
        checks++;
        if (addr !== 4'hE) begin
            errors++;
            $display("FAIL addr_set: addr=%h, required e", addr);
        end
        send_byte(8'h11, 1); model_accept(8'h11);
        send_byte(8'h22, 1); model_accept(8'h22);
        send_byte(8'h33, 1); model_accept(8'h33);
        checks++;
        if (mem[14] !== 8'h11 || mem[15] !== 8'h22 || mem[0] !== 8'h33) begin
            errors++;
            $display("FAIL wrap_data: mem[e]=%h mem[f]=%h mem[0]=%h, required 11 22 33", mem[14], mem[15], mem[0]);
        end
        checks++;
        if (done_count - d0 !== 1 || addr !== 4'h1) begin
            errors++;
            $display("FAIL wrap_done: done_pulses=%0d addr=%h, required 1 1", done_count - d0, addr);
        end
    endtask

    task automatic test_overrun();
        int         wc;
        logic [3:0] a0;
        wc       = wr_count;
        a0       = 4'(exp_addr);
        ui_in    = 8'hC3;
        new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
        ui_in    = 8'h3C;
        tick();
        new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
        wait_idle();
        tick();
        model_accept(8'hC3);
        checks++;
        if (overrun !== 1'b1 || addr !== 4'(exp_addr) || mem[a0] !== 8'hC3 || wr_count !== wc + 1) begin
            errors++;
            $display("FAIL overrun: ovr=%b addr=%h mem=%h writes=%0d, required 1 %h c3 1",
                     overrun, addr, mem[a0], wr_count - wc, 4'(exp_addr));
        end
        programming = 1'b0;
        tick();
        checks++;
        if (overrun !== 1'b0 || addr !== 4'h0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b addr=%h, required 0 0", overrun, addr);
        end
        programming = 1'b1;
        exp_addr    = 0;
        tick();
    endtask

    task automatic test_prog_drop();
        int wc;
        ui_in    = 8'h05;
        addr_set = 1'b1;
        tick();
        addr_set = 1'b0;
        exp_addr = 5;
        wc       = wr_count;
        ui_in    = 8'h77;
        new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
        tick();
        programming = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ctrl !== 15'h0FE3 || bus_oe !== 1'b0 || addr !== 4'h0) begin
            errors++;
            $display("FAIL prog_drop: busy=%b ctrl=%h oe=%b addr=%h, required 0 0fe3 0 0", busy, ctrl, bus_oe, addr);
        end
        tick();
        tick();
        checks++;
        if (wr_count !== wc) begin
            errors++;
            $display("FAIL prog_drop_noload: ram loads=%0d, required 0", wr_count - wc);
        end
        programming = 1'b1;
        exp_addr    = 0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         a;
        int         wc;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                ui_in    = 8'($urandom);
                addr_set = 1'b1;
                tick();
                addr_set = 1'b0;
                exp_addr = int'(ui_in[3:0]);
            end else begin
                b  = 8'($urandom);
                a  = exp_addr;
                wc = wr_count;
                send_byte(b, $urandom_range(1, LAT + 3));
                model_accept(b);
                checks++;
                if (mem[a] !== b || wr_count !== wc + 1) begin
                    errors++;
                    $display("FAIL random_write[%0d]: mem[%h]=%h writes=%0d, required %h 1",
                             n, 4'(a), mem[a], wr_count - wc, b);
                end
            end
        end
        checks++;
        if (addr !== 4'(exp_addr) || overrun !== 1'b0 || verify_err !== 1'b0) begin
            errors++;
            $display("FAIL random_end: addr=%h ovr=%b verr=%b, required %h 0 0", addr, overrun, verify_err, 4'(exp_addr));
        end
        begin
            int bad = 0;
            for (int i = 0; i < 16; i++) if (mem[i] !== exp_mem[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ram_image: %0d words differ, required 0", bad);
            end
        end
        checks++;
        if (done_count !== exp_done) begin
            errors++;
            $display("FAIL done_total: pulses=%0d, required %0d", done_count, exp_done);
        end
    endtask

`ifdef PROG_VERIFY_EN
    task automatic test_verify();
        checks++;
        if (verify_err !== 1'b0) begin
            errors++;
            $display("FAIL verify_match: verr=%b, required 0", verify_err);
        end
        corrupt = 1'b1;
        send_byte(8'hA5, 1);
        model_accept(8'hA5);
        corrupt = 1'b0;
        checks++;
        if (verify_err !== 1'b1) begin
            errors++;
            $display("FAIL verify_mismatch: verr=%b, required 1", verify_err);
        end
        programming = 1'b0;
        tick();
        checks++;
        if (verify_err !== 1'b1) begin
            errors++;
            $display("FAIL verify_sticky: verr=%b, required 1", verify_err);
        end
        programming = 1'b1;
        exp_addr    = 0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        ui_in    = 8'h99;
        new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (ctrl !== 15'h0FE3 || bus_oe !== 1'b0 || addr !== 4'h0 || busy !== 1'b0 ||
            verify_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ctrl=%h oe=%b addr=%h busy=%b verr=%b ovr=%b, required 0fe3 0 0 0 0 0",
                     ctrl, bus_oe, addr, busy, verify_err, overrun);
        end
        tick();
        resetn   = 1'b1;
        exp_addr = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        test_reset();
        test_single_byte();
        test_wrap_done();
        test_overrun();
        test_prog_drop();
        test_random();
`ifdef PROG_VERIFY_EN
        test_verify();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised RAM loader. It writes a stream of user bytes into the CPU's RAM through the shared bus and the 15-bit control word.
- Each accepted byte triggers a fixed micro-sequence:
  - drive the address to the MAR,
  - drive the data to the MAR data latch,
  - pulse RAM load.
- Adds configurable data/address width, a settable start address, overrun detection, wrap/done reporting, and optional write-verify.
- Sits beside the controller; its control word is muxed in while `programming` is high.

Parameters:
- DATA_W, 8, bus and RAM word width
- ADDR_W, 4, RAM address width (depth = 2^ADDR_W); ADDR_W <= DATA_W
- CTRL_W, 15, control word width; fixed bit map below, CTRL_W >= 15

Ports:
- clk  in  1  system clock, all state on posedge
- resetn  in  1  reset; asynchronous, active-low
- programming  in  1  programming mode enable, synchronous level
- new_byte  in  1  byte strobe; rising edge detected internally
- addr_set  in  1  in IDLE, load ui_in[ADDR_W-1:0] as next write address
- ui_in  in  DATA_W  user data / start address
- bus_in  in  DATA_W  bus readback (used only with verify)
- bus_out  out  DATA_W  value to drive on shared bus
- bus_oe  out  1  bus drive enable; top level tristates bus_out with it
- ctrl  out  CTRL_W  control word, registered
- addr  out  ADDR_W  next RAM address to be written
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the top address is written
- overrun  out  1  sticky: byte edge arrived while busy
- verify_err  out  1  sticky readback mismatch

Behaviour:
- Control bit map:
  - 14 PC_INC, 13 PC_EN, 12 PC_LOAD
  - 11 MAR_ADDR_LOAD_N, 10 MAR_MEM_LOAD_N
  - 9 RAM_EN_N, 8 RAM_LOAD_N
  - 7 IR_LOAD_N, 6 IR_EN_N
  - 5 REGA_LOAD_N, 4 REGA_EN
  - 3 ADDER_SUB, 2 REGB_EN, 1 REGB_LOAD_N, 0 OUT_LOAD_N
  - Idle word CTRL_IDLE = 15'h0FE3; bits above 14 are 0.
- Reset (resetn low, async):
  - state=IDLE, ctrl=CTRL_IDLE, addr=0
  - data_reg=0, new_byte_q=0
  - bus_out=0, bus_oe=0, busy=0, done=0, overrun=0, verify_err=0
- Edge detect: new_byte_q <= new_byte every cycle; edge = new_byte & ~new_byte_q.
- FSM states: IDLE, ADDR, DATA, WRITE, NEXT (plus READ with verify). Each non-IDLE state lasts exactly 1 cycle.
- IDLE:
  - edge & programming: data_reg <= ui_in, go ADDR.
  - else if addr_set & programming: addr <= ui_in[ADDR_W-1:0].
  - edge has priority over addr_set in the same cycle; addr_set is then ignored.
- ADDR: bus_out = zero-extended addr, bus_oe=1, ctrl[11]=0.
- DATA: bus_out = data_reg, bus_oe=1, ctrl[10]=0.
- WRITE: bus_out = data_reg, bus_oe=1, ctrl[8]=0.
- NEXT:
  - addr <= addr+1, wrapping mod 2^ADDR_W.
  - If addr was all-ones, done=1 for this cycle.
  - Go IDLE.
- All other ctrl bits hold CTRL_IDLE values in every state. ctrl, bus_out and bus_oe are registered and reflect the current state.
- Latency: edge sampled in cycle N (IDLE) → ADDR in N+1, DATA N+2, WRITE N+3, NEXT N+4, IDLE N+5. Minimum byte spacing is 5 cycles.
- Overrun: edge while state != IDLE sets overrun=1; the byte is dropped and the sequence is unaffected.
- programming low:
  - Next clock: state=IDLE, ctrl=CTRL_IDLE, bus_oe=0, addr=0, overrun=0.
  - An in-flight sequence aborts without a RAM load pulse, unless already in WRITE; WRITE completes its single cycle.
  - verify_err is not cleared.
- new_byte held high produces one edge only.

Optional Feature:
- Macro: PROG_VERIFY_EN.
- Defined:
  - Add READ between WRITE and NEXT.
  - In READ: bus_oe=0, ctrl[9]=0.
  - Compare bus_in to data_reg at end of READ; on mismatch set verify_err.
  - Latency becomes 6 cycles; min spacing 6.
  - verify_err clears only on reset.
- Undefined: no READ state; verify_err tied 0; bus_in unused.

Test Plan:
- Reset mid-sequence: resetn low during DATA → immediately ctrl=15'h0FE3, bus_oe=0, addr=0, busy=0.
- programming=1, new_byte edge with ui_in=8'hA5 at addr 0:
  - ADDR: ctrl=15'h07E3, bus_out=8'h00.
  - DATA: ctrl=15'h0BE3, bus_out=8'hA5.
  - WRITE: ctrl=15'h0EE3.
  - Then addr=1, busy 4 cycles (5 with verify).
- addr_set with ui_in=8'h0E, then three bytes 11/22/33 spaced 6 cycles:
  - writes to addresses E, F, 0.
  - done pulses once after the F write; final addr=1.
- Second edge 2 cycles after first → overrun=1; only first byte written; addr advances by 1; overrun cleared by programming low.
- programming dropped during DATA → next cycle IDLE, no ctrl[8] low pulse, addr=0.
- PROG_VERIFY_EN:
  - bus_in returns 8'h5A for written 8'hA5 → verify_err=1 after READ.
  - Matching readback leaves verify_err=0.
